// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared constants for the EX/MEM pipeline register: default widths,
// forwarding-select encodings and the data value loaded on reset/flush.
package ex_mem_pipe_reg_pkg;
  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [15:0] RST_DATA = 16'h0000;
endpackage

// File: rtl/ex_mem_pipe_reg_forward_unit.sv
// EX operand forwarding selector: picks the newest in-flight producer of each
// source register, EX/MEM before MEM/WB; r0 is never forwarded.
module forward_unit
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          regWrite_pipe_3,
  input  logic          valid_pipe_3,
  input  logic [RW-1:0] write_reg_pipe_3,
  input  logic          regWrite_pipe_4,
  input  logic [RW-1:0] write_reg_pipe_4,
  input  logic [RW-1:0] rs_ex,
  input  logic [RW-1:0] rt_ex,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);
  logic mem_hit_ok, wb_hit_ok;

  assign mem_hit_ok = regWrite_pipe_3 && valid_pipe_3 && (write_reg_pipe_3 != '0);
  assign wb_hit_ok  = regWrite_pipe_4 && (write_reg_pipe_4 != '0);

  function automatic logic [1:0] sel(input logic [RW-1:0] src);
    if (mem_hit_ok && (write_reg_pipe_3 == src))     sel = FWD_MEM;
    else if (wb_hit_ok && (write_reg_pipe_4 == src)) sel = FWD_WB;
    else                                             sel = FWD_RF;
  endfunction

  assign fwd_a = sel(rs_ex);
  assign fwd_b = sel(rt_ex);
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures execute results for the memory stage,
// resolves taken branches and hosts the EX forwarding selector.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_ex,
  input  logic [DW-1:0] branch_target,
  input  logic          zero,
  input  logic [DW-1:0] aluResult,
  input  logic [RW-1:0] write_reg_ex,
  input  logic [DW-1:0] store_data_ex,
  input  logic          branch_ex,
  input  logic          memRead_ex,
  input  logic          memWrite_ex,
  input  logic          regWrite_ex,
  input  logic          memToReg_ex,
  input  logic [RW-1:0] rs_ex,
  input  logic [RW-1:0] rt_ex,
  input  logic          regWrite_pipe_4,
  input  logic [RW-1:0] write_reg_pipe_4,
  output logic          valid_pipe_3,
  output logic [DW-1:0] branch_target_pipe_3,
  output logic [DW-1:0] aluResult_pipe_3,
  output logic [DW-1:0] store_data_pipe_3,
  output logic          zero_pipe_3,
  output logic [RW-1:0] write_reg_pipe_3,
  output logic          memRead_pipe_3,
  output logic          memWrite_pipe_3,
  output logic          regWrite_pipe_3,
  output logic          memToReg_pipe_3,
  output logic          pc_src,
  output logic          flush_front,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);
  localparam logic [DW-1:0] ZD = DW'(RST_DATA);

  logic branch_pipe_3;
  logic taken_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe_3         <= 1'b0;
      branch_target_pipe_3 <= ZD;
      aluResult_pipe_3     <= ZD;
      store_data_pipe_3    <= ZD;
      zero_pipe_3          <= 1'b0;
      write_reg_pipe_3     <= '0;
      branch_pipe_3        <= 1'b0;
      memRead_pipe_3       <= 1'b0;
      memWrite_pipe_3      <= 1'b0;
      regWrite_pipe_3      <= 1'b0;
      memToReg_pipe_3      <= 1'b0;
      taken_done           <= 1'b0;
    end else if (flush) begin
      valid_pipe_3         <= 1'b0;
      branch_target_pipe_3 <= ZD;
      aluResult_pipe_3     <= ZD;
      store_data_pipe_3    <= ZD;
      zero_pipe_3          <= 1'b0;
      write_reg_pipe_3     <= '0;
      branch_pipe_3        <= 1'b0;
      memRead_pipe_3       <= 1'b0;
      memWrite_pipe_3      <= 1'b0;
      regWrite_pipe_3      <= 1'b0;
      memToReg_pipe_3      <= 1'b0;
      taken_done           <= 1'b0;
    end else if (stall) begin
      // Held entry: remember a redirect already issued so it is not repeated.
      taken_done <= taken_done | pc_src;
    end else begin
      valid_pipe_3         <= valid_ex;
      branch_target_pipe_3 <= branch_target;
      aluResult_pipe_3     <= aluResult;
      store_data_pipe_3    <= store_data_ex;
      zero_pipe_3          <= zero;
      write_reg_pipe_3     <= write_reg_ex;
      // Bubbles carry no side effects downstream.
      branch_pipe_3        <= branch_ex   & valid_ex;
      memRead_pipe_3       <= memRead_ex  & valid_ex;
      memWrite_pipe_3      <= memWrite_ex & valid_ex;
      regWrite_pipe_3      <= regWrite_ex & valid_ex;
      memToReg_pipe_3      <= memToReg_ex & valid_ex;
      taken_done           <= 1'b0;
    end
  end

  assign pc_src      = valid_pipe_3 & branch_pipe_3 & zero_pipe_3 & ~stall & ~taken_done;
  assign flush_front = pc_src;

  forward_unit #(.RW(RW)) u_fwd (
    .regWrite_pipe_3 (regWrite_pipe_3),
    .valid_pipe_3    (valid_pipe_3),
    .write_reg_pipe_3(write_reg_pipe_3),
    .regWrite_pipe_4 (regWrite_pipe_4),
    .write_reg_pipe_4(write_reg_pipe_4),
    .rs_ex           (rs_ex),
    .rt_ex           (rt_ex),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );
endmodule
